// File: rtl/mips_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | mips_pkg                                                             |
// | Shared types and constants for the MIPS fetch front end.             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package mips_pkg;

  // Fetch sequencer states
  typedef enum logic [1:0] {
    ISSUE = 2'd0,  // present a request to instruction memory
    WAIT  = 2'd1,  // request outstanding, response wanted
    DROP  = 2'd2,  // request outstanding, response to be discarded
    HOLD  = 2'd3   // response parked in the hold buffer behind a stall
  } fetch_state_t;

  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam int          IMM_MSB          = 15;
  localparam int          IMM_LSB          = 0;
  localparam int          PC_STEP          = 4;

endpackage : mips_pkg
`default_nettype wire

// File: rtl/if_id_reg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | if_id_reg                                                            |
// | IF/ID pipeline register: instruction, pc+4 and valid flag, with      |
// | clear > load > stall > consume priority.                             |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module if_id_reg #(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              clear,         // flush or redirect this cycle
  input  logic              load,          // new instruction arrives
  input  logic              stall,         // decode holds current contents
  input  logic [31:0]       load_instr,
  input  logic [ADDR_W-1:0] load_pc_plus4,
  output logic [31:0]       instr,
  output logic [ADDR_W-1:0] pc_plus4,
  output logic              valid
);

  // Data fields only change on a load; they stay stale when valid drops.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      instr    <= '0;
      pc_plus4 <= '0;
      valid    <= 1'b0;
    end else if (clear) begin
      valid    <= 1'b0;
    end else if (load) begin
      instr    <= load_instr;
      pc_plus4 <= load_pc_plus4;
      valid    <= 1'b1;
    end else if (!stall) begin
      valid    <= 1'b0;
    end
  end

endmodule : if_id_reg
`default_nettype wire

// File: rtl/fetch_stage.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | fetch_stage                                                          |
// | Instruction fetch: PC, single-outstanding memory request sequencer,  |
// | one-entry hold buffer and IF/ID register feeding sign extension.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module fetch_stage
  import mips_pkg::*;
#(
  parameter int                ADDR_W   = 32,
  parameter logic [ADDR_W-1:0] RESET_PC = ADDR_W'(RESET_PC_DEFAULT)
) (
  input  logic              clk,
  input  logic              reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_rvalid,
  input  logic [31:0]       imem_rdata,
  input  logic              stall_d,
  input  logic              flush_d,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic [31:0]       instr_d,
  output logic [ADDR_W-1:0] pc_plus4_d,
  output logic              valid_d,
  output logic [15:0]       imm_d,
  output logic              busy
);

  fetch_state_t      state, next_state;
  logic [ADDR_W-1:0] pc, next_pc;
  logic [ADDR_W-1:0] pc_next_seq;
  logic [31:0]       hold_buf;
  logic              buf_load;
  logic              ifid_load;
  logic [31:0]       ifid_instr;
  logic              can_accept;

  // Increment wraps naturally at the top of the address space.
  assign pc_next_seq = pc + ADDR_W'(PC_STEP);
  assign can_accept  = !valid_d || !stall_d;

  // Request is masked during reset since the state register already reads ISSUE.
  assign imem_req  = (state == ISSUE) && !redirect_valid && !reset;
  assign imem_addr = pc;
  assign busy      = (state == WAIT) || (state == DROP);
  assign imm_d     = instr_d[IMM_MSB:IMM_LSB];

  // State, PC and hold buffer registers.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= ISSUE;
      pc       <= RESET_PC;
      hold_buf <= '0;
    end else begin
      state <= next_state;
      pc    <= next_pc;
      if (buf_load) hold_buf <= imem_rdata;
    end
  end

  // Next-state, next-PC and IF/ID load decisions.
  always_comb begin
    next_state = state;
    next_pc    = pc;
    ifid_load  = 1'b0;
    ifid_instr = imem_rdata;
    buf_load   = 1'b0;
    case (state)
      ISSUE: begin
        if (redirect_valid) next_pc    = redirect_pc;
        else                next_state = WAIT;
      end
      WAIT: begin
        if (imem_rvalid) begin
          if (redirect_valid) begin
            next_pc    = redirect_pc;
            next_state = ISSUE;
          end else if (can_accept) begin
            ifid_load  = 1'b1;
            next_pc    = pc_next_seq;
            next_state = ISSUE;
          end else begin
            buf_load   = 1'b1;
            next_state = HOLD;
          end
        end else if (redirect_valid) begin
          next_pc    = redirect_pc;
          next_state = DROP;
        end
      end
      DROP: begin
        if (redirect_valid) next_pc    = redirect_pc;
        if (imem_rvalid)    next_state = ISSUE;
      end
      HOLD: begin
        if (redirect_valid) begin
          next_pc    = redirect_pc;
          next_state = ISSUE;
        end else if (!stall_d) begin
          ifid_load  = 1'b1;
          ifid_instr = hold_buf;
          next_pc    = pc_next_seq;
          next_state = ISSUE;
        end
      end
      default: next_state = ISSUE;
    endcase
  end

  if_id_reg #(
    .ADDR_W(ADDR_W)
  ) u_if_id (
    .clk          (clk),
    .reset        (reset),
    .clear        (flush_d || redirect_valid),
    .load         (ifid_load),
    .stall        (stall_d),
    .load_instr   (ifid_instr),
    .load_pc_plus4(pc_next_seq),
    .instr        (instr_d),
    .pc_plus4     (pc_plus4_d),
    .valid        (valid_d)
  );

endmodule : fetch_stage
`default_nettype wire
